// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew register-hazard stall detection plus mult/div busy sequencing
// and a saturating stall-cycle counter for the five-stage MIPS core.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       D_A1,
  input  logic [4:0]       D_A2,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_IsMD,
  input  logic [4:0]       E_A3,
  input  logic [4:0]       M_A3,
  input  logic             E_RFWr,
  input  logic             M_RFWr,
  input  logic [1:0]       E_Tnew,
  input  logic [1:0]       M_Tnew,
  input  logic [2:0]       E_MDOp,
  output logic             Stall,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Cnt
);
  localparam int MAX_C = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W  = $clog2(MAX_C + 1) < 4 ? 4 : $clog2(MAX_C + 1);
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md;
  // Tuse of 3 marks an operand the D instruction never reads; Tnew of 0 can never exceed Tuse.
  assign stall_rs = (D_A1 != 5'd0) && (D_Tuse_rs != 2'd3) &&
                    ((D_A1 == E_A3 && E_RFWr && D_Tuse_rs < E_Tnew) ||
                     (D_A1 == M_A3 && M_RFWr && D_Tuse_rs < M_Tnew));
  assign stall_rt = (D_A2 != 5'd0) && (D_Tuse_rt != 2'd3) &&
                    ((D_A2 == E_A3 && E_RFWr && D_Tuse_rt < E_Tnew) ||
                     (D_A2 == M_A3 && M_RFWr && D_Tuse_rt < M_Tnew));
  // D holds HI/LO users while busy, so a start can only reach E when the unit is idle.
  assign MD_Start  = (E_MDOp >= 3'd1) && (E_MDOp <= 3'd4);
  assign MD_Busy   = (md_cnt_q != '0);
  assign stall_md  = D_IsMD && (MD_Start || MD_Busy);
  assign Stall     = stall_rs || stall_rt || stall_md;
  assign Stall_Cnt = stall_cnt_q;
  always_comb begin
    md_cnt_d    = MD_Start ? (E_MDOp <= 3'd2 ? MD_W'(MULT_CYCLES) : MD_W'(DIV_CYCLES))
                           : (MD_Busy ? md_cnt_q - MD_W'(1) : '0);
    stall_cnt_d = (Stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl; a reference model pushes
// expected outputs per cycle and the monitor step pops and compares them.
module tb_hazard_stall_ctrl;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  D_A1, D_A2, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_IsMD, E_RFWr, M_RFWr;
  logic [2:0]  E_MDOp;
  logic        Stall, MD_Start, MD_Busy;
  logic [15:0] Stall_Cnt;
  typedef struct {
    logic st;
    logic ms;
    logic mb;
    int   sc;
  } exp_t;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   m_sc = 0;
  int   busy_n;
  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs),
    .D_Tuse_rt(D_Tuse_rt), .D_IsMD(D_IsMD), .E_A3(E_A3), .M_A3(M_A3), .E_RFWr(E_RFWr),
    .M_RFWr(M_RFWr), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .E_MDOp(E_MDOp), .Stall(Stall),
    .MD_Start(MD_Start), .MD_Busy(MD_Busy), .Stall_Cnt(Stall_Cnt)
  );
  always #5 Clk = ~Clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, need finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic m_hz(input logic [4:0] a, input logic [1:0] tu);
    return a != 0 && tu != 3 && ((a == E_A3 && E_RFWr && tu < E_Tnew) ||
                                 (a == M_A3 && M_RFWr && tu < M_Tnew));
  endfunction
  function automatic logic m_start();
    return E_MDOp inside {3'd1, 3'd2, 3'd3, 3'd4};
  endfunction
  function automatic logic m_stall();
    return m_hz(D_A1, D_Tuse_rs) || m_hz(D_A2, D_Tuse_rt) || (D_IsMD && (m_start() || m_cnt != 0));
  endfunction
  // One cycle: model predicts, DUT is compared, then the model advances on the edge.
  task automatic cyc(input string tag);
    exp_t e, g;
    logic st;
    #1;
    st = m_stall();
    e.st = st;
    e.ms = m_start();
    e.mb = (m_cnt != 0);
    e.sc = m_sc;
    sb.push_back(e);
    g = sb.pop_front();
    check({tag, ".stall"}, Stall, g.st);
    check({tag, ".start"}, MD_Start, g.ms);
    check({tag, ".busy"}, MD_Busy, g.mb);
    check({tag, ".cnt"}, Stall_Cnt, g.sc);
    @(posedge Clk);
    if (Rst_n) begin
      m_cnt = e.ms ? (E_MDOp <= 2 ? 5 : 10) : (m_cnt != 0 ? m_cnt - 1 : 0);
      if (st && m_sc < 65535) m_sc++;
    end
    @(negedge Clk);
  endtask
  task automatic clr();
    D_A1 = 0; D_A2 = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_IsMD = 0;
    E_A3 = 0; M_A3 = 0; E_RFWr = 0; M_RFWr = 0; E_Tnew = 0; M_Tnew = 0; E_MDOp = 0;
  endtask
  initial begin
    clr();
    Rst_n = 0;
    @(negedge Clk);
    cyc("reset");
    check("reset_busy", MD_Busy, 0);
    check("reset_cnt", Stall_Cnt, 0);
    Rst_n = 1;
    // load-use on rs
    D_A1 = 8; D_Tuse_rs = 1; E_A3 = 8; E_RFWr = 1; E_Tnew = 2;
    #1 check("lu_stall", Stall, 1);
    cyc("lu0");
    E_A3 = 0; E_RFWr = 0; E_Tnew = 0; M_A3 = 8; M_RFWr = 1; M_Tnew = 1;
    #1 check("lu_release", Stall, 0);
    check("lu_cnt", Stall_Cnt, 1);
    cyc("lu1");
    clr();
    // $0 and unread operands never stall
    E_A3 = 0; E_RFWr = 1; E_Tnew = 2; D_A1 = 0; D_Tuse_rs = 0;
    #1 check("r0", Stall, 0);
    cyc("r0");
    clr();
    D_A2 = 8; D_Tuse_rt = 3; E_A3 = 8; E_RFWr = 1; E_Tnew = 2;
    #1 check("rt_unused", Stall, 0);
    cyc("rt_unused");
    D_Tuse_rt = 0;
    #1 check("rt_hz", Stall, 1);
    cyc("rt_hz");
    E_Tnew = 0; M_A3 = 8; M_RFWr = 1; M_Tnew = 0;
    #1 check("tnew0", Stall, 0);
    cyc("tnew0");
    clr();
    E_MDOp = 5; D_IsMD = 1;
    #1 check("op5_start", MD_Start, 0);
    cyc("op5");
    check("op5_busy", MD_Busy, 0);
    // mult with mflo waiting in D, plus a register hazard overlapping cycle 3
    E_MDOp = 1;
    #1 check("mul_start", MD_Start, 1);
    check("mul_stall0", Stall, 1);
    cyc("mul0");
    E_MDOp = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin D_A1 = 9; D_Tuse_rs = 0; E_A3 = 9; E_RFWr = 1; E_Tnew = 2; end
      if (i == 4) begin D_A1 = 0; E_A3 = 0; E_RFWr = 0; E_Tnew = 0; end
      #1 check($sformatf("mul_busy%0d", i), MD_Busy, 1);
      check($sformatf("mul_stall%0d", i), Stall, 1);
      cyc($sformatf("mul%0d", i));
    end
    #1 check("mul_done_busy", MD_Busy, 0);
    check("mul_done_stall", Stall, 0);
    check("mul_cnt", Stall_Cnt, 8);
    cyc("mul6");
    // div with non-MD instruction in D
    D_IsMD = 0; E_MDOp = 3;
    #1 check("div_stall0", Stall, 0);
    cyc("div0");
    E_MDOp = 0;
    busy_n = 0;
    for (int i = 1; i <= 12; i++) begin
      #1 if (MD_Busy) busy_n++;
      cyc($sformatf("div%0d", i));
    end
    check("div_busy_len", busy_n, 10);
    check("div_cnt", Stall_Cnt, 8);
    // async reset partway through a div busy window
    E_MDOp = 4; D_IsMD = 1;
    cyc("rdiv0");
    E_MDOp = 0;
    cyc("rdiv1");
    cyc("rdiv2");
    #2 Rst_n = 0;
    m_cnt = 0;
    m_sc = 0;
    #1 check("rst_busy", MD_Busy, 0);
    check("rst_cnt", Stall_Cnt, 0);
    check("rst_stall", Stall, 0);
    @(negedge Clk);
    Rst_n = 1;
    cyc("post_rst");
    check("post_rst_cnt", Stall_Cnt, 0);
    // saturation
    clr();
    D_A1 = 8; D_Tuse_rs = 0; E_A3 = 8; E_RFWr = 1; E_Tnew = 2;
    repeat (70000) @(posedge Clk);
    m_sc = 65535;
    @(negedge Clk);
    check("sat_cnt", Stall_Cnt, 16'hFFFF);
    cyc("sat");
    check("sat_hold", Stall_Cnt, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
